// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
//   Shared constants, FSM state type and address-field helpers for the
//   direct-mapped, write-through, no-write-allocate data cache.
//   Word address layout: {tag[TAG_W], index[INDEX_W], offset[OFFSET_W]}.
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << OFFSET_W;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [OFFSET_W-1:0] offset_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_e;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic index_t addr_index(input addr_t a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic offset_t addr_offset(input addr_t a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage : dcache_pkg

// File: rtl/dcache_array.sv
// -----------------------------------------------------------------------------
// dcache_array
//   Tag, valid and data storage for the data cache.
//   - Combinational read of valid/tag for a line and of one data word.
//   - Synchronous single-word data write (refill word or write-through hit).
//   - Synchronous line fill: sets valid and stores the tag.
//   - Valid bits clear asynchronously on reset; tag/data are never reset.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rd_index_i        line selected for lookup
//   rd_offset_i       word selected for the read data
//   rd_valid_o        valid bit of the selected line
//   rd_tag_o          stored tag of the selected line
//   rd_data_o         selected data word
//   wr_en_i           write one data word
//   wr_index_i        line to write
//   wr_offset_i       word to write
//   wr_data_i         data to write
//   fill_en_i         mark line valid and store its tag
//   fill_index_i      line to mark
//   fill_tag_i        tag to store
// -----------------------------------------------------------------------------
module dcache_array
  import dcache_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  index_t  rd_index_i,
  input  offset_t rd_offset_i,
  output logic    rd_valid_o,
  output tag_t    rd_tag_o,
  output data_t   rd_data_o,
  input  logic    wr_en_i,
  input  index_t  wr_index_i,
  input  offset_t wr_offset_i,
  input  data_t   wr_data_i,
  input  logic    fill_en_i,
  input  index_t  fill_index_i,
  input  tag_t    fill_tag_i
);

  logic [LINES-1:0] valid_q;
  tag_t             tag_q  [LINES];
  data_t            data_q [LINES][WORDS];

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_index_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays deliberately have no reset; a cleared valid bit
  // makes their contents irrelevant, and resetting them would prevent
  // mapping onto RAM.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_index_i] <= fill_tag_i;
    end
    if (wr_en_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

endmodule : dcache_array

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Data-side cache controller for a single-cycle core. Read hits return data
//   combinationally with no stall. Read misses refill a 4-word line from
//   word-addressed memory; all stores are written through to memory and only
//   update the cache on a hit (no write-allocate).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mem_read     load request from the decoder
//   mem_write    store request from the decoder (wins over mem_read)
//   addr         word address {tag, index, offset}
//   wdata        store data
//   rdata        load data, valid when mem_read & ~stall, else 0
//   stall        freezes PC and register writes while high
//   m_req        memory request
//   m_we         memory write enable, qualified by m_req
//   m_addr       memory word address
//   m_wdata      memory write data
//   m_rdata      memory read data, valid with m_ready
//   m_ready      one-cycle completion pulse for the current m_req
// -----------------------------------------------------------------------------
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  localparam offset_t LAST_WORD = offset_t'(WORDS - 1);

  state_e  state_q, state_d;
  offset_t cnt_q, cnt_d;

  tag_t    req_tag;
  index_t  req_index;
  offset_t req_offset;

  logic    line_valid;
  tag_t    line_tag;
  data_t   line_word;
  logic    hit;

  logic    arr_we;
  offset_t arr_woff;
  data_t   arr_wdata;
  logic    arr_fill;

  assign req_tag    = addr_tag(addr);
  assign req_index  = addr_index(addr);
  assign req_offset = addr_offset(addr);

  dcache_array u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_index_i   (req_index),
    .rd_offset_i  (req_offset),
    .rd_valid_o   (line_valid),
    .rd_tag_o     (line_tag),
    .rd_data_o    (line_word),
    .wr_en_i      (arr_we),
    .wr_index_i   (req_index),
    .wr_offset_i  (arr_woff),
    .wr_data_i    (arr_wdata),
    .fill_en_i    (arr_fill),
    .fill_index_i (req_index),
    .fill_tag_i   (req_tag)
  );

  assign hit = line_valid & (line_tag == req_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    rdata     = '0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    arr_we    = 1'b0;
    arr_woff  = req_offset;
    arr_wdata = wdata;
    arr_fill  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_write) begin
          // A simultaneous read is illegal; the store takes priority.
          stall   = 1'b1;
          state_d = WRITE;
        end else if (mem_read) begin
          if (hit) begin
            rdata = line_word;
          end else begin
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end

      REFILL: begin
        stall  = 1'b1;
        m_req  = 1'b1;
        m_addr = {req_tag, req_index, cnt_q};
        if (m_ready) begin
          arr_we    = 1'b1;
          arr_woff  = cnt_q;
          arr_wdata = m_rdata;
          cnt_d     = cnt_q + offset_t'(1);
          // The line becomes valid only together with its last word.
          if (cnt_q == LAST_WORD) begin
            arr_fill = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      WRITE: begin
        stall   = 1'b1;
        m_req   = 1'b1;
        m_we    = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        if (m_ready) begin
          // Write-through: refresh the cached copy only if the line is present.
          arr_we  = hit;
          state_d = WDONE;
        end
      end

      WDONE: begin
        // One unstalled cycle lets the store retire before the next request.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule : dcache_ctrl
